fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage: owns the program counter and issues single-outstanding AHB-Lite instruction reads. Each returned word is presented with its PC and branch-prediction fields, and decode latches them on `f2d_en`. The block is the producing end of the fetch-to-decode pipeline register. It honours decode stalls by buffering, and execute-stage redirects by flushing decode and discarding in-flight data.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_haddr`  out  32  AHB address; equals `pc` in ADDR, otherwise don't-care (drive `pc`).
- `imem_htrans`  out  2  2'b10 NONSEQ in ADDR, otherwise 2'b00 IDLE.
- `imem_hready`  in  1  AHB ready; completes an address or data phase.
- `imem_hrdata`  in  32  instruction word, valid in the data phase when `imem_hready`=1.
- `bp_predict`  in  1  combinational predictor lookup for `imem_haddr`: predict taken.
- `bp_target`  in  32  predicted target for `imem_haddr`.
- `stall`  in  1  decode cannot accept this cycle.
- `redirect`  in  1  mispredict or jump resolved; refetch from `redirect_pc`.
- `redirect_pc`  in  32  corrected PC.
- `f2d_en`  out  1  decode latches the `f2d_*` fields this cycle.
- `f2d_flush`  out  1  decode clears its latch (bubble).
- `f2d_pc`  out  32  PC of the presented instruction.
- `f2d_inst`  out  32  instruction word.
- `f2d_branch_predict`  out  1  prediction captured at fetch.
- `f2d_branch_target`  out  32  predicted target captured at fetch.

## Operation

**Registers**
- `pc`, `state`, `req_pc`, `req_pred`, `req_tgt`, `inst_buf`.

**Reset**
- `pc`=RESET_PC, `state`=ADDR.
- `req_pc`, `req_pred`, `req_tgt`, `inst_buf` all 0.
- While `rst`=1: `imem_htrans`=IDLE, `f2d_en`=0, `f2d_flush`=0.

**States**
- **ADDR**
  - Drive NONSEQ at `pc`.
  - On `imem_hready`=1: `req_pc`←`pc`, `req_pred`←`bp_predict`, `req_tgt`←`bp_target`.
  - Also `pc`←`bp_predict` ? `bp_target` : `pc`+4, then go to DATA.
  - On `imem_hready`=0: hold.
- **DATA**
  - Drive IDLE; `f2d_inst`=`imem_hrdata`.
  - On `imem_hready`=1 with `stall`=0: `f2d_en`=1, go to ADDR.
  - On `imem_hready`=1 with `stall`=1: `inst_buf`←`imem_hrdata`, go to HOLD.
- **HOLD**
  - Drive IDLE; `f2d_inst`=`inst_buf`.
  - On `stall`=0: `f2d_en`=1, go to ADDR.
- **DRAIN**
  - Drive IDLE; wait for `imem_hready`=1, discard the data, go to ADDR.
- In every state, `f2d_pc`/`f2d_branch_predict`/`f2d_branch_target` = `req_pc`/`req_pred`/`req_tgt`.

**Redirect** (priority over everything, including `stall`)
- `f2d_flush`=1, `f2d_en`=0, `pc`←`redirect_pc`.
- In ADDR: force `imem_htrans`=IDLE this cycle, so no transfer is issued; stay in ADDR.
- In DATA with `imem_hready`=1: data discarded; go to ADDR.
- In DATA with `imem_hready`=0: go to DRAIN. AHB transfers cannot be aborted.
- In HOLD: buffered instruction dropped; go to ADDR.
- In DRAIN: stay in DRAIN, or go to ADDR if `imem_hready`=1 this cycle.

**Arithmetic and checks**
- `pc`+4 is modulo 2^32; FFFF_FFFC wraps to 0000_0000.
- `bp_target` and `redirect_pc` are used unmodified; there is no alignment check.

## Timing
- One transfer outstanding at a time.
- With `imem_hready` always 1 and no stall, throughput is one instruction per 2 cycles.
- Latency from address-phase acceptance to `f2d_en` is 1 cycle plus data-phase wait states.
- `f2d_en` and `f2d_flush` are combinational from state and inputs; decode samples them at the same edge.
- `f2d_en` and `f2d_flush` are never both 1.
- `f2d_en`=1 exactly once per accepted, unsquashed fetch.
- After a redirect, the first NONSEQ to `redirect_pc` appears:
  - the next cycle, from ADDR, DATA or HOLD;
  - the cycle after drain completes, from DRAIN.
- `rst` mid-transfer: the next cycle is ADDR at RESET_PC.
  - Any outstanding data phase is not tracked.
  - The bench must also reset the slave.

## Test plan
- Reset with `RESET_PC`=0x100, `imem_hready`=1, no stall, `bp_predict`=0:
  - NONSEQ at 0x100, 0x104, 0x108 on cycles 0, 2, 4;
  - `f2d_en` on cycles 1, 3, 5 with `f2d_pc`=0x100/0x104/0x108 and `f2d_inst`=`imem_hrdata`.
- `bp_predict`=1, `bp_target`=0x200 during the address phase at 0x104:
  - `f2d_branch_predict`=1, `f2d_branch_target`=0x200 with `f2d_pc`=0x104;
  - next NONSEQ at 0x200.
- `stall`=1 for 3 cycles while data returns 0xDEADBEEF:
  - state goes to HOLD, no `f2d_en` during the stall, IDLE on the bus;
  - `f2d_en`=1 with `f2d_inst`=0xDEADBEEF in the first unstalled cycle; then NONSEQ at pc+4.
- `redirect`=1, `redirect_pc`=0x400 during DATA with `imem_hready`=0 for 2 more cycles:
  - `f2d_flush`=1, state goes to DRAIN, returned data never sees `f2d_en`;
  - NONSEQ at 0x400 the cycle after `imem_hready` rises.
- `redirect` while `stall`=1 in HOLD, and `redirect` in ADDR with `imem_hready`=1:
  - HOLD case: flush, no `f2d_en`, next NONSEQ at `redirect_pc`;
  - ADDR case: `imem_htrans`=IDLE that cycle, no transfer at the old PC.
- PC wrap: `RESET_PC`=0xFFFF_FFFC → second fetch at 0x0000_0000.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one AHB-Lite read at a time and
// presents each returned word with its PC and prediction to decode.
//
// state | meaning
// ADDR  | address phase: NONSEQ at pc, waiting for hready
// DATA  | data phase: word returns when hready=1
// HOLD  | decode stalled; returned word parked in inst_buf
// DRAIN | redirected mid data phase; waiting to discard the returning word
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_haddr,
  output logic [1:0]  imem_htrans,
  input  logic        imem_hready,
  input  logic [31:0] imem_hrdata,
  input  logic        bp_predict,
  input  logic [31:0] bp_target,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        f2d_en,
  output logic        f2d_flush,
  output logic [31:0] f2d_pc,
  output logic [31:0] f2d_inst,
  output logic        f2d_branch_predict,
  output logic [31:0] f2d_branch_target
);

  typedef enum logic [1:0] {ST_ADDR, ST_DATA, ST_HOLD, ST_DRAIN} state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        req_pred_q, req_pred_d;
  logic [31:0] req_tgt_q, req_tgt_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic [1:0]  htrans;
  logic        en;
  logic        flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ADDR;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      req_pred_q <= 1'b0;
      req_tgt_q  <= '0;
      inst_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      req_pred_q <= req_pred_d;
      req_tgt_q  <= req_tgt_d;
      inst_buf_q <= inst_buf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    req_pred_d = req_pred_q;
    req_tgt_d  = req_tgt_q;
    inst_buf_d = inst_buf_q;
    htrans     = HTRANS_IDLE;
    en         = 1'b0;
    flush      = 1'b0;

    if (redirect) begin
      // An accepted data phase cannot be aborted, so DATA without hready must drain.
      flush = 1'b1;
      pc_d  = redirect_pc;
      case (state_q)
        ST_ADDR:  state_d = ST_ADDR;
        ST_DATA:  state_d = imem_hready ? ST_ADDR : ST_DRAIN;
        ST_HOLD:  state_d = ST_ADDR;
        ST_DRAIN: state_d = imem_hready ? ST_ADDR : ST_DRAIN;
        default:  state_d = ST_ADDR;
      endcase
    end else begin
      case (state_q)
        ST_ADDR: begin
          htrans = HTRANS_NONSEQ;
          if (imem_hready) begin
            req_pc_d   = pc_q;
            req_pred_d = bp_predict;
            req_tgt_d  = bp_target;
            pc_d       = bp_predict ? bp_target : pc_q + 32'd4;
            state_d    = ST_DATA;
          end
        end
        ST_DATA: begin
          if (imem_hready) begin
            if (!stall) begin
              en      = 1'b1;
              state_d = ST_ADDR;
            end else begin
              inst_buf_d = imem_hrdata;
              state_d    = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            en      = 1'b1;
            state_d = ST_ADDR;
          end
        end
        ST_DRAIN: begin
          if (imem_hready) state_d = ST_ADDR;
        end
        default: state_d = ST_ADDR;
      endcase
    end

    if (rst) begin
      htrans = HTRANS_IDLE;
      en     = 1'b0;
      flush  = 1'b0;
    end
  end

  assign imem_haddr         = pc_q;
  assign imem_htrans        = htrans;
  assign f2d_en             = en;
  assign f2d_flush          = flush;
  assign f2d_pc             = req_pc_q;
  assign f2d_branch_predict = req_pred_q;
  assign f2d_branch_target  = req_tgt_q;
  assign f2d_inst           = (state_q == ST_HOLD) ? inst_buf_q : imem_hrdata;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, prediction, stall/hold,
// redirect in DATA/HOLD/ADDR, reset mid-transfer, and PC wrap (second instance).
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_haddr;
  logic [1:0]  imem_htrans;
  logic        imem_hready;
  logic [31:0] imem_hrdata;
  logic        bp_predict;
  logic [31:0] bp_target;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        f2d_en, f2d_flush, f2d_branch_predict;
  logic [31:0] f2d_pc, f2d_inst, f2d_branch_target;

  logic [31:0] w_haddr, w_pc, w_inst, w_tgt;
  logic [1:0]  w_htrans;
  logic        w_en, w_flush, w_pred;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst(rst),
    .imem_haddr(imem_haddr), .imem_htrans(imem_htrans),
    .imem_hready(imem_hready), .imem_hrdata(imem_hrdata),
    .bp_predict(bp_predict), .bp_target(bp_target),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .f2d_en(f2d_en), .f2d_flush(f2d_flush), .f2d_pc(f2d_pc), .f2d_inst(f2d_inst),
    .f2d_branch_predict(f2d_branch_predict), .f2d_branch_target(f2d_branch_target)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_haddr(w_haddr), .imem_htrans(w_htrans),
    .imem_hready(imem_hready), .imem_hrdata(imem_hrdata),
    .bp_predict(bp_predict), .bp_target(bp_target),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .f2d_en(w_en), .f2d_flush(w_flush), .f2d_pc(w_pc), .f2d_inst(w_inst),
    .f2d_branch_predict(w_pred), .f2d_branch_target(w_tgt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are then changed and outputs sampled mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; imem_hready = 1'b1; imem_hrdata = '0;
    bp_predict = 1'b0; bp_target = '0; stall = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    step();
    sample();
    check("rst_htrans", {30'd0, imem_htrans}, 32'd0);
    check("rst_en", {31'd0, f2d_en}, 32'd0);
    check("rst_flush", {31'd0, f2d_flush}, 32'd0);
    step();
    rst = 1'b0;

    // sequential fetch, cycles 0..5
    sample();
    check("c0_htrans", {30'd0, imem_htrans}, 32'd2);
    check("c0_haddr", imem_haddr, 32'h100);
    check("wrap_c0_haddr", w_haddr, 32'hFFFF_FFFC);
    step(); imem_hrdata = 32'h1111_1111; sample();
    check("c1_en", {31'd0, f2d_en}, 32'd1);
    check("c1_htrans", {30'd0, imem_htrans}, 32'd0);
    check("c1_pc", f2d_pc, 32'h100);
    check("c1_inst", f2d_inst, 32'h1111_1111);
    step(); sample();
    check("c2_haddr", imem_haddr, 32'h104);
    check("c2_htrans", {30'd0, imem_htrans}, 32'd2);
    check("c2_en", {31'd0, f2d_en}, 32'd0);
    check("wrap_c2_haddr", w_haddr, 32'h0000_0000);
    step(); imem_hrdata = 32'h2222_2222; sample();
    check("c3_en", {31'd0, f2d_en}, 32'd1);
    check("c3_pc", f2d_pc, 32'h104);
    check("c3_inst", f2d_inst, 32'h2222_2222);
    step(); sample();
    check("c4_haddr", imem_haddr, 32'h108);
    step(); imem_hrdata = 32'h3333_3333; sample();
    check("c5_en", {31'd0, f2d_en}, 32'd1);
    check("c5_pc", f2d_pc, 32'h108);
    step(); step();

    // reset asserted during a data phase: no f2d_en, then ADDR at RESET_PC
    rst = 1'b1; sample();
    check("midrst_en", {31'd0, f2d_en}, 32'd0);
    check("midrst_htrans", {30'd0, imem_htrans}, 32'd0);
    step(); step();
    rst = 1'b0; sample();
    check("post_rst_haddr", imem_haddr, 32'h100);
    check("post_rst_htrans", {30'd0, imem_htrans}, 32'd2);
    check("post_rst_pc", f2d_pc, 32'h0);

    // prediction captured at 0x104
    step(); step();
    bp_predict = 1'b1; bp_target = 32'h200; sample();
    check("bp_haddr", imem_haddr, 32'h104);
    step(); bp_predict = 1'b0; bp_target = 32'h0; imem_hrdata = 32'h4444_4444; sample();
    check("bp_en", {31'd0, f2d_en}, 32'd1);
    check("bp_pc", f2d_pc, 32'h104);
    check("bp_pred", {31'd0, f2d_branch_predict}, 32'd1);
    check("bp_tgt", f2d_branch_target, 32'h200);
    step(); sample();
    check("bp_next_haddr", imem_haddr, 32'h200);
    check("bp_next_htrans", {30'd0, imem_htrans}, 32'd2);

    // 3-cycle stall while data 0xDEADBEEF returns
    step(); stall = 1'b1; imem_hrdata = 32'hDEAD_BEEF; sample();
    check("st0_en", {31'd0, f2d_en}, 32'd0);
    check("st0_htrans", {30'd0, imem_htrans}, 32'd0);
    step(); imem_hrdata = 32'h0; sample();
    check("st1_en", {31'd0, f2d_en}, 32'd0);
    check("st1_htrans", {30'd0, imem_htrans}, 32'd0);
    check("st1_inst", f2d_inst, 32'hDEAD_BEEF);
    step(); sample();
    check("st2_en", {31'd0, f2d_en}, 32'd0);
    step(); stall = 1'b0; sample();
    check("st_rel_en", {31'd0, f2d_en}, 32'd1);
    check("st_rel_inst", f2d_inst, 32'hDEAD_BEEF);
    check("st_rel_pc", f2d_pc, 32'h200);
    step(); sample();
    check("st_next_haddr", imem_haddr, 32'h204);
    check("st_next_htrans", {30'd0, imem_htrans}, 32'd2);

    // redirect in DATA with wait states -> DRAIN
    step(); imem_hready = 1'b0; redirect = 1'b1; redirect_pc = 32'h400; sample();
    check("dr_flush", {31'd0, f2d_flush}, 32'd1);
    check("dr_en", {31'd0, f2d_en}, 32'd0);
    step(); redirect = 1'b0; sample();
    check("dr1_htrans", {30'd0, imem_htrans}, 32'd0);
    check("dr1_en", {31'd0, f2d_en}, 32'd0);
    check("dr1_flush", {31'd0, f2d_flush}, 32'd0);
    step(); sample();
    check("dr2_en", {31'd0, f2d_en}, 32'd0);
    step(); imem_hready = 1'b1; imem_hrdata = 32'hBAD0_BAD0; sample();
    check("dr3_en", {31'd0, f2d_en}, 32'd0);
    check("dr3_htrans", {30'd0, imem_htrans}, 32'd0);
    step(); sample();
    check("dr_next_haddr", imem_haddr, 32'h400);
    check("dr_next_htrans", {30'd0, imem_htrans}, 32'd2);

    // redirect while stalled in HOLD
    step(); stall = 1'b1; imem_hrdata = 32'h1234_5678; sample();
    check("hr0_en", {31'd0, f2d_en}, 32'd0);
    step(); redirect = 1'b1; redirect_pc = 32'h500; sample();
    check("hr_flush", {31'd0, f2d_flush}, 32'd1);
    check("hr_en", {31'd0, f2d_en}, 32'd0);
    step(); redirect = 1'b0; stall = 1'b0; imem_hready = 1'b0; sample();
    check("hr_next_haddr", imem_haddr, 32'h500);
    check("hr_next_htrans", {30'd0, imem_htrans}, 32'd2);

    // redirect in ADDR with hready=1: no transfer at 0x500
    step(); imem_hready = 1'b1; redirect = 1'b1; redirect_pc = 32'h600; sample();
    check("ar_htrans", {30'd0, imem_htrans}, 32'd0);
    check("ar_flush", {31'd0, f2d_flush}, 32'd1);
    step(); redirect = 1'b0; sample();
    check("ar_next_haddr", imem_haddr, 32'h600);
    check("ar_next_htrans", {30'd0, imem_htrans}, 32'd2);
    step(); imem_hrdata = 32'hCAFE_F00D; sample();
    check("ar_en", {31'd0, f2d_en}, 32'd1);
    check("ar_pc", f2d_pc, 32'h600);
    check("ar_inst", f2d_inst, 32'hCAFE_F00D);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
